// File: rtl/led_blink_decoder.sv
`default_nettype none
// =============================================================================
//  Module   : led_blink_decoder
//  Purpose  : Recovers the 2-bit blink-rate code from an LED drive waveform by
//             timing its half-periods; reports lock, stuck line and lock breaks.
//  Revision : 1.0 - initial release
// =============================================================================
module led_blink_decoder #(
   parameter int CLKS_100HZ = 125,
   parameter int CLKS_50HZ  = 250,
   parameter int CLKS_10HZ  = 1250,
   parameter int CLKS_1HZ   = 12500,
   parameter int TOL        = 4,
   parameter int TIMEOUT    = 25000
) (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic i_enable,
   input  logic i_led_drive,
   output logic o_switch_1,
   output logic o_switch_2,
   output logic o_valid,
   output logic o_stuck,
   output logic o_glitch
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int DW = CW + 1;
   localparam logic [CW-1:0] c_timeout = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMED  = 2'd1,
      S_CAND   = 2'd2,
      S_LOCKED = 2'd3
   } state_t;

   logic          r_sync1;
   logic          r_sync2;
   logic          r_prev;
   logic          w_edge;
   logic [CW-1:0] r_cnt;
   state_t        r_state;
   state_t        w_state_next;
   logic [1:0]    r_cand;
   logic [1:0]    w_cand_next;
   logic          r_valid;
   logic          w_valid_next;
   logic [1:0]    r_sw;
   logic [1:0]    w_sw_next;
   logic          r_stuck;
   logic          w_stuck_next;
   logic          r_glitch;
   logic          w_glitch_next;
   logic          w_match;
   logic [1:0]    w_code;

   // One extra bit keeps the difference from wrapping for any counter value.
   function automatic logic in_window(input logic [CW-1:0] m, input int clks);
      logic [DW-1:0] mm;
      logic [DW-1:0] cc;
      logic [DW-1:0] d;
      mm = {1'b0, m};
      cc = DW'(clks);
      d  = (mm >= cc) ? (mm - cc) : (cc - mm);
      return (d <= DW'(TOL));
   endfunction

   // Synchronizer keeps running while disabled so re-enable sees no false edge.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= i_led_drive;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_edge = r_sync2 ^ r_prev;

   always_comb begin
      w_match = 1'b1;
      w_code  = 2'd0;
      if (in_window(r_cnt, CLKS_100HZ)) begin
         w_code = 2'd0;
      end else if (in_window(r_cnt, CLKS_50HZ)) begin
         w_code = 2'd1;
      end else if (in_window(r_cnt, CLKS_10HZ)) begin
         w_code = 2'd2;
      end else if (in_window(r_cnt, CLKS_1HZ)) begin
         w_code = 2'd3;
      end else begin
         w_match = 1'b0;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_cand_next   = r_cand;
      w_valid_next  = r_valid;
      w_sw_next     = r_sw;
      w_stuck_next  = r_stuck;
      w_glitch_next = 1'b0;
      if (w_edge) begin
         w_stuck_next = 1'b0;
         case (r_state)
            S_IDLE: begin
               w_state_next = S_ARMED;
            end
            S_ARMED: begin
               if (w_match) begin
                  w_state_next = S_CAND;
                  w_cand_next  = w_code;
               end
            end
            S_CAND: begin
               if (!w_match) begin
                  w_state_next = S_ARMED;
               end else if (w_code == r_cand) begin
                  w_state_next = S_LOCKED;
                  w_valid_next = 1'b1;
                  w_sw_next    = r_cand;
               end else begin
                  w_cand_next = w_code;
               end
            end
            S_LOCKED: begin
               if (!w_match) begin
                  w_state_next  = S_ARMED;
                  w_valid_next  = 1'b0;
                  w_glitch_next = 1'b1;
               end else if (w_code != r_cand) begin
                  w_state_next = S_CAND;
                  w_cand_next  = w_code;
                  w_valid_next = 1'b0;
               end
            end
            default: begin
               w_state_next = S_IDLE;
            end
         endcase
      end else if ((r_state != S_IDLE) && (r_cnt == c_timeout)) begin
         w_state_next = S_IDLE;
         w_valid_next = 1'b0;
         w_stuck_next = 1'b1;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_cand   <= 2'd0;
         r_valid  <= 1'b0;
         r_sw     <= 2'd0;
         r_stuck  <= 1'b0;
         r_glitch <= 1'b0;
      end else if (!i_enable) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_cand   <= 2'd0;
         r_valid  <= 1'b0;
         r_sw     <= 2'd0;
         r_stuck  <= 1'b0;
         r_glitch <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_cand   <= w_cand_next;
         r_valid  <= w_valid_next;
         r_sw     <= w_sw_next;
         r_stuck  <= w_stuck_next;
         r_glitch <= w_glitch_next;
         if (w_edge) begin
            r_cnt <= CW'(1);
         end else if (r_cnt != c_timeout) begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_switch_1 = r_sw[1];
   assign o_switch_2 = r_sw[0];
   assign o_valid    = r_valid;
   assign o_stuck    = r_stuck;
   assign o_glitch   = r_glitch;

endmodule
`default_nettype wire

// File: tb/tb_led_blink_decoder.sv
`default_nettype none
// =============================================================================
//  Module   : tb_led_blink_decoder
//  Purpose  : Self-checking bench; half-period sequences against a
//             measurement-level reference model of the decoder.
//  Revision : 1.0 - initial release
// =============================================================================
module tb_led_blink_decoder;

   localparam int TIMEOUT = 25000;
   localparam int TOL     = 4;
   localparam int CLKS[4] = '{125, 250, 1250, 12500};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic en    = 1'b1;
   logic led   = 1'b0;
   logic sw1;
   logic sw2;
   logic valid;
   logic stuck;
   logic glitch;

   led_blink_decoder dut (
      .i_clock     (clk),
      .i_reset_n   (rst_n),
      .i_enable    (en),
      .i_led_drive (led),
      .o_switch_1  (sw1),
      .o_switch_2  (sw2),
      .o_valid     (valid),
      .o_stuck     (stuck),
      .o_glitch    (glitch)
   );

   always #5 clk = ~clk;

   int n_total     = 0;
   int n_bad       = 0;
   int cyc         = 0;
   int last_t      = 0;
   int glitch_exp  = 0;
   int glitch_seen = 0;

   // Reference model: lock means the last two measurements agree on a code.
   bit m_armed  = 1'b0;
   bit m_valid  = 1'b0;
   bit m_stuck  = 1'b0;
   bit m_glitch = 1'b0;
   int m_prev   = -1;
   int m_sw     = 0;

   always @(posedge clk) begin
      if (glitch) glitch_seen <= glitch_seen + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int classify(input int m);
      for (int c = 0; c < 4; c++) begin
         if ((m >= CLKS[c] - TOL) && (m <= CLKS[c] + TOL)) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_armed  = 1'b0;
      m_valid  = 1'b0;
      m_stuck  = 1'b0;
      m_glitch = 1'b0;
      m_prev   = -1;
      m_sw     = 0;
   endtask

   task automatic model_edge();
      int gap;
      int c;
      gap      = cyc - last_t;
      last_t   = cyc;
      m_glitch = 1'b0;
      m_stuck  = 1'b0;
      if (!m_armed) begin
         m_armed = 1'b1;
         m_prev  = -1;
      end else begin
         c = classify(gap);
         if (c < 0) begin
            if (m_valid) begin
               m_glitch = 1'b1;
               glitch_exp++;
            end
            m_valid = 1'b0;
            m_prev  = -1;
         end else begin
            if (c == m_prev) begin
               m_valid = 1'b1;
               m_sw    = c;
            end else begin
               m_valid = 1'b0;
            end
            m_prev = c;
         end
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      cyc += k;
      #1;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_valid"},  32'(valid),      32'(m_valid));
      chk({tag, "_switch"}, 32'({sw1, sw2}), 32'(m_sw));
      chk({tag, "_glitch"}, 32'(glitch),     32'(m_glitch));
      chk({tag, "_stuck"},  32'(stuck),      32'(m_stuck));
   endtask

   // Toggle the line, check the result one clock before and at the update, then hold n clocks.
   task automatic half(input int n);
      bit old_valid;
      old_valid = m_valid;
      led = ~led;
      model_edge();
      step(2);
      chk("valid_early", 32'(valid), 32'(old_valid));
      step(1);
      check_outputs("edge");
      step(n - 3);
   endtask

   initial begin
      int n;
      int prev_n;
      int c;
      #2;
      chk("reset_outputs", 32'({sw1, sw2, valid, stuck, glitch}), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(5);
      chk("idle_valid", 32'(valid), 32'd0);

      // 125-clock square wave: locks to 00 and stays locked.
      for (int i = 0; i < 21; i++) half(125);

      // Locked at 01, then the blinker switches to 11 mid-half-period.
      for (int i = 0; i < 6; i++) half(250);
      half(150);
      half(12500);
      half(12500);

      // Tolerance edges, and a lone out-of-window half-period inside a lock.
      for (int i = 0; i < 4; i++) half(254);
      for (int i = 0; i < 4; i++) half(255);
      for (int i = 0; i < 4; i++) half(250);
      half(255);
      for (int i = 0; i < 3; i++) half(250);

      // Locked at 10, then the line freezes.
      for (int i = 0; i < 4; i++) half(1250);
      led = ~led;
      model_edge();
      step(3);
      check_outputs("freeze_edge");
      step(TIMEOUT - 1);
      chk("stuck_before", 32'(stuck), 32'd0);
      chk("valid_before", 32'(valid), 32'(m_valid));
      step(1);
      m_armed = 1'b0;
      m_valid = 1'b0;
      m_stuck = 1'b1;
      chk("stuck_at_timeout", 32'(stuck), 32'd1);
      chk("valid_at_timeout", 32'(valid), 32'd0);
      step(20);
      chk("stuck_held", 32'(stuck), 32'd1);

      // Alternating 125/250 never locks; first toggle clears stuck.
      for (int i = 0; i < 10; i++) half((i % 2 == 0) ? 125 : 250);

      // Enable drop while locked, then re-lock.
      for (int i = 0; i < 4; i++) half(125);
      led = ~led;
      model_edge();
      step(3);
      check_outputs("pre_disable");
      step(20);
      en = 1'b0;
      step(1);
      chk("disable_clear", 32'({sw1, sw2, valid, stuck, glitch}), 32'd0);
      model_reset();
      step(30);
      en = 1'b1;
      step(5);
      for (int i = 0; i < 4; i++) half(250);

      // Asynchronous reset mid-count, then re-lock.
      led = ~led;
      model_edge();
      step(3);
      check_outputs("pre_reset");
      step(40);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_clear", 32'({sw1, sw2, valid, stuck, glitch}), 32'd0);
      led = 1'b0;
      step(10);
      rst_n = 1'b1;
      model_reset();
      step(3);
      for (int i = 0; i < 4; i++) half(125);

      // Randomized half-periods near the 00/01 windows, with repeats to form locks.
      prev_n = 250;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) < 6) begin
            n = prev_n;
         end else begin
            c = int'($urandom_range(0, 1));
            n = CLKS[c] + int'($urandom_range(0, 12)) - 6;
         end
         prev_n = n;
         half(n);
      end

      step(5);
      chk("glitch_pulse_count", 32'(glitch_seen), 32'(glitch_exp));
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
